// File: rtl/ddi_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : ddi_frame_tx
// Description : UART transmitter for the DDI link. On start it sends one frame
//               made of the HEADER byte, PAYLOAD_LEN image bytes pulled from a
//               valid/ready stream, and an 8-bit additive checksum of the
//               payload. Each byte is sent as start bit, 8 data bits LSB
//               first and a stop bit.
//               Optional feature macro: DDI_TX_PARITY_EN adds an even-parity
//               bit before the stop bit of every byte.
// Revision    : 1.0 - initial release
// ============================================================================
module ddi_frame_tx #(
  parameter int          CLK_FREQ    = 100_000_000,
  parameter int          BAUD_RATE   = 9600,
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter int          PAYLOAD_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int              c_div       = CLK_FREQ / BAUD_RATE;
  localparam int              c_cw        = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_cw-1:0] c_baud_last = c_cw'(c_div - 1);
`ifdef DDI_TX_PARITY_EN
  localparam int              c_nbits     = 11;
`else
  localparam int              c_nbits     = 10;
`endif
  // Bits still to go after the start bit: data (+ parity) + stop
  localparam int              c_sw        = c_nbits - 1;
  localparam logic [3:0]      c_last_bit  = 4'(c_nbits - 1);
  localparam logic [8:0]      c_len       = 9'(PAYLOAD_LEN);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_hdr  = 2'd1;
  localparam logic [1:0] c_st_pay  = 2'd2;
  localparam logic [1:0] c_st_csum = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic            r_ser_busy;
  logic [c_cw-1:0] r_baud;
  logic [3:0]      r_bit;
  logic [c_sw-1:0] r_shift;
  logic            r_tx;
  logic [7:0]      r_csum;
  logic [8:0]      r_cnt;
  logic            r_frame_done;

  logic            w_load;
  logic [7:0]      w_load_byte;
  logic            w_accept;
  logic            w_bit_end;
  logic            w_stop_end;
  logic [c_sw-1:0] w_frame;

  assign w_bit_end  = r_ser_busy && (r_baud == c_baud_last);
  assign w_stop_end = w_bit_end && (r_bit == c_last_bit);

  // Bits shifted out after the start bit; a 1 fill keeps the line idle high
`ifdef DDI_TX_PARITY_EN
  assign w_frame = {1'b1, ^w_load_byte, w_load_byte};
`else
  assign w_frame = {1'b1, w_load_byte};
`endif

  assign tx         = r_tx;
  assign frame_done = r_frame_done;

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next;
  end

  // Frame sequencing: header, payload bytes, checksum
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: if (start)                            w_next = c_st_hdr;
      c_st_hdr:  if (w_stop_end)                       w_next = c_st_pay;
      c_st_pay:  if (!r_ser_busy && (r_cnt == c_len))  w_next = c_st_csum;
      c_st_csum: if (w_stop_end)                       w_next = c_st_idle;
      default:                                         w_next = c_st_idle;
    endcase
  end

  // Stream handshake and serializer load selection for each state
  always_comb begin
    busy        = (r_state != c_st_idle);
    data_ready  = (r_state == c_st_pay) && !r_ser_busy && (r_cnt != c_len);
    w_accept    = data_ready && data_valid;
    w_load      = 1'b0;
    w_load_byte = HEADER;
    case (r_state)
      c_st_idle: w_load = start;
      c_st_pay: begin
        if (!r_ser_busy && (r_cnt == c_len)) begin
          w_load      = 1'b1;
          w_load_byte = r_csum;
        end else if (w_accept) begin
          w_load      = 1'b1;
          w_load_byte = data_in;
        end
      end
      default: w_load = 1'b0;
    endcase
  end

  // Serializer: a load drives the start bit at once and restarts the bit timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ser_busy <= 1'b0;
      r_baud     <= '0;
      r_bit      <= 4'd0;
      r_shift    <= '1;
      r_tx       <= 1'b1;
    end else if (w_load) begin
      r_ser_busy <= 1'b1;
      r_baud     <= '0;
      r_bit      <= 4'd0;
      r_shift    <= w_frame;
      r_tx       <= 1'b0;
    end else if (r_ser_busy) begin
      if (r_baud == c_baud_last) begin
        r_baud <= '0;
        if (r_bit == c_last_bit) begin
          // Stop bit finished; stay idle-high for at least one clock
          r_ser_busy <= 1'b0;
          r_tx       <= 1'b1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[c_sw-1:1]};
        end
      end else begin
        r_baud <= r_baud + c_cw'(1);
      end
    end
  end

  // Payload byte count and running checksum, cleared when a frame begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= 8'd0;
      r_cnt  <= 9'd0;
    end else if ((r_state == c_st_idle) && start) begin
      r_csum <= 8'd0;
      r_cnt  <= 9'd0;
    end else if (w_accept) begin
      r_csum <= r_csum + data_in;
      r_cnt  <= r_cnt + 9'd1;
    end
  end

  // Completion pulse coincides with busy dropping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_frame_done <= 1'b0;
    else     r_frame_done <= (r_state == c_st_csum) && w_stop_end;
  end

endmodule
`default_nettype wire
